status_transmitter: RTL and testbench

- Transmit-side counterpart to the flag-city action decoder.
- Takes a programmed sequence of desired actions (idle/wander/evade/first_aid) and encodes each action into the status code that provokes it (no_change/fit/attacked/hurt).
- Streams the codes out as 2-bit symbols, MSB-first, over a valid/ready handshake.
- Also presents the packed 16-bit status word so a board-level harness can drive a status bus directly.

---
 rtl/flag_city_pkg.sv | 29 ++
 rtl/status_transmitter_if.sv | 31 +++
 rtl/status_encoder.sv | 24 ++
 rtl/status_transmitter.sv | 143 ++++++++++++++
 tb/tb_status_transmitter.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flag_city_pkg.sv
// Package: flag_city_pkg
// Shared definitions for the flag-city status link.
//   - ACT_*  : desired-action codes (idle/wander/evade/first_aid)
//   - ST_*   : status codes that provoke those actions at the decoder
//   - tx_state_e : status_transmitter FSM states
//   - DEST_LOC   : destination location of the status bus
package flag_city_pkg;

  // Desired actions, as carried in seq_in.
  localparam logic [1:0] ACT_IDLE      = 2'b00;
  localparam logic [1:0] ACT_WANDER    = 2'b01;
  localparam logic [1:0] ACT_EVADE     = 2'b10;
  localparam logic [1:0] ACT_FIRST_AID = 2'b11;

  // Status codes understood by the action decoder.
  localparam logic [1:0] ST_FIT       = 2'b00;
  localparam logic [1:0] ST_ATTACKED  = 2'b01;
  localparam logic [1:0] ST_HURT      = 2'b10;
  localparam logic [1:0] ST_NO_CHANGE = 2'b11;

  localparam logic [3:0] DEST_LOC = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } tx_state_e;

endpackage

// File: rtl/status_transmitter_if.sv
// Interface: status_transmitter_if
// Symbol stream between the status transmitter and its consumer.
//   sym_out   : current 2-bit status symbol
//   sym_valid : sym_out is valid
//   sym_idx   : index of the symbol currently presented
//   sym_ready : consumer accepts the current symbol
// Modports: master (transmitter side), slave (consumer side).
interface status_transmitter_if #(
  parameter int unsigned IDX_W = 3
);

  logic [1:0]       sym_out;
  logic             sym_valid;
  logic [IDX_W-1:0] sym_idx;
  logic             sym_ready;

  modport master (
    output sym_out,
    output sym_valid,
    output sym_idx,
    input  sym_ready
  );

  modport slave (
    input  sym_out,
    input  sym_valid,
    input  sym_idx,
    output sym_ready
  );

endinterface

// File: rtl/status_encoder.sv
// Module: status_encoder
// Pure combinational map from a desired action to the status code that
// provokes it at the decoder. The map is total.
//   act    in  2  desired action (ACT_*)
//   status out 2  status code (ST_*)
module status_encoder
  import flag_city_pkg::*;
(
  input  logic [1:0] act,
  output logic [1:0] status
);

  always_comb begin
    status = ST_NO_CHANGE;
    unique case (act)
      ACT_IDLE:      status = ST_NO_CHANGE;
      ACT_WANDER:    status = ST_FIT;
      ACT_EVADE:     status = ST_ATTACKED;
      ACT_FIRST_AID: status = ST_HURT;
      default:       status = ST_NO_CHANGE;
    endcase
  end

endmodule

// File: rtl/status_transmitter.sv
// Module: status_transmitter
// Encodes a programmed sequence of SEQ_LEN desired actions into status codes
// and streams them out MSB-first as 2-bit symbols over a valid/ready
// handshake. The whole encoded word is also presented on word_out.
//
// Ports:
//   clk       in   1          system clock, rising edge
//   rst       in   1          asynchronous reset, active-low
//   start     in   1          latch seq_in and begin (honoured only when idle)
//   seq_in    in   2*SEQ_LEN  action sequence, action k at [2*SEQ_LEN-1-2k -: 2]
//   sym_if    master         sym_out/sym_valid/sym_idx out, sym_ready in
//   word_out  out  2*SEQ_LEN  encoded status word, same ordering as seq_in
//   busy      out  1          high while not IDLE
//   done      out  1          one-cycle pulse after the last symbol is accepted
//
// Build option: STATUS_LOOP_EN -- when defined, the block wraps back to
// symbol 0 after the last transfer and keeps streaming the latched word,
// pulsing done once per pass. A start held high during a last-symbol
// transfer ends the stream after that pass.
module status_transmitter
  import flag_city_pkg::*;
#(
  parameter int unsigned SEQ_LEN = 8,
  parameter int unsigned IDX_W   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2*SEQ_LEN-1:0]   seq_in,
  status_transmitter_if.master   sym_if,
  output logic [2*SEQ_LEN-1:0]   word_out,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned WordW = 2 * SEQ_LEN;

  // Symbol idx of word w, symbol 0 in the top two bits.
  function automatic logic [1:0] sym_at(input logic [WordW-1:0] w,
                                        input logic [IDX_W-1:0] i);
    logic [WordW-1:0] shifted;
    shifted = w << {i, 1'b0};
    return shifted[WordW-1 -: 2];
  endfunction

  logic [WordW-1:0] enc_word;

  for (genvar k = 0; k < SEQ_LEN; k++) begin : g_enc
    status_encoder u_enc (
      .act    (seq_in[WordW-1-2*k -: 2]),
      .status (enc_word[WordW-1-2*k -: 2])
    );
  end

  tx_state_e        state_q;
  logic [WordW-1:0] word_q;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       sym_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  logic             xfer;
  logic             last;
  logic [IDX_W-1:0] idx_nxt;
  logic [1:0]       sym_nxt;

  always_comb begin
    xfer    = valid_q && sym_if.sym_ready;
    last    = (idx_q == IDX_W'(SEQ_LEN - 1));
    idx_nxt = idx_q + IDX_W'(1);
    sym_nxt = sym_at(word_q, idx_nxt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      sym_q   <= 2'b00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            word_q  <= enc_word;
            idx_q   <= '0;
            sym_q   <= enc_word[WordW-1 -: 2];
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            if (!last) begin
              idx_q <= idx_nxt;
              sym_q <= sym_nxt;
            end else begin
`ifdef STATUS_LOOP_EN
              done_q <= 1'b1;
              if (start) begin
                // Terminate after this pass; DONE is never visited.
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end else begin
                idx_q <= '0;
                sym_q <= word_q[WordW-1 -: 2];
              end
`else
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
`endif
            end
          end
        end
        DONE: begin
          // done_q was raised on entry and drops via the default above.
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sym_if.sym_out   = sym_q;
  assign sym_if.sym_valid = valid_q;
  assign sym_if.sym_idx   = idx_q;
  assign word_out         = word_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_status_transmitter.sv
module tb_status_transmitter;

  localparam int unsigned SEQ_LEN = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned W       = 2 * SEQ_LEN;
`ifdef STATUS_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic         clk    = 1'b0;
  logic         rst    = 1'b0;
  logic         start  = 1'b0;
  logic [W-1:0] seq_in = '0;
  logic [W-1:0] word_out;
  logic         busy;
  logic         done;

  status_transmitter_if #(.IDX_W(IDX_W)) sym_if ();

  status_transmitter #(
    .SEQ_LEN (SEQ_LEN),
    .IDX_W   (IDX_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .seq_in   (seq_in),
    .sym_if   (sym_if),
    .word_out (word_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // action -> status table, indexed by action code
  logic [1:0] act2st [4] = '{2'b11, 2'b00, 2'b01, 2'b10};

  logic [1:0]   m_q [$];          // symbols still to be transferred
  int           m_idx     = 0;
  logic [W-1:0] m_word    = '0;
  bit           m_busy    = 1'b0;
  bit           m_done    = 1'b0;
  bit           m_in_done = 1'b0;

  function automatic logic [W-1:0] encode_word(input logic [W-1:0] s);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < SEQ_LEN; k++) r[W-1-2*k -: 2] = act2st[s[W-1-2*k -: 2]];
    return r;
  endfunction

  task automatic refill();
    m_q.delete();
    for (int k = 0; k < SEQ_LEN; k++) m_q.push_back(m_word[W-1-2*k -: 2]);
    m_idx = 0;
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_q.delete();
      m_idx = 0; m_word = '0; m_busy = 0; m_done = 0; m_in_done = 0;
    end else begin
      m_done = 0;
      if (m_in_done) begin
        m_in_done = 0;
        m_busy    = 0;
      end else if (!m_busy) begin
        if (start) begin
          m_word = encode_word(seq_in);
          refill();
          m_busy = 1;
        end
      end else if (sym_if.sym_ready && m_q.size() != 0) begin
        void'(m_q.pop_front());
        m_idx++;
        if (m_q.size() == 0) begin
          m_done = 1;
          if (!LOOP) m_in_done = 1;
          else if (start) m_busy = 0;
          else refill();
        end
      end
    end
  end

  // ---------------- compare process ----------------
  logic [1:0] got [$];

  initial forever begin
    @(negedge clk);
    if (rst) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("word_out", word_out, m_word);
      check("sym_valid", sym_if.sym_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        check("sym_out", sym_if.sym_out, m_q[0]);
        check("sym_idx", sym_if.sym_idx, m_idx);
      end
      if (sym_if.sym_valid && sym_if.sym_ready) got.push_back(sym_if.sym_out);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Start a transmission and wait (bounded) for done. lat = edges from the
  // start-accepting edge to the edge that raises done.
  task automatic run_seq(input logic [W-1:0] s, input int stall_at, input int stall_len,
                         input bit rnd, input int mid_start_at, output int lat);
    int stalled;
    got.delete();
    stalled = 0;
    lat = -1;
    seq_in = s;
    start = 1'b1;
    sym_if.sym_ready = 1'b1;
    tick();
    start = 1'b0;
    seq_in = 16'($urandom);
    for (int c = 1; c <= 300; c++) begin
      if (rnd) sym_if.sym_ready = 1'($urandom_range(0, 1));
      else if (stall_at >= 0 && int'(sym_if.sym_idx) == stall_at && stalled < stall_len) begin
        sym_if.sym_ready = 1'b0;
        stalled++;
      end else sym_if.sym_ready = 1'b1;
      start = (c == mid_start_at);
      if (start) seq_in = 16'($urandom);
      tick();
      if (done) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
    check("done_seen", lat >= 0, 1);
    tick();
    tick();
  endtask

  logic [1:0] exp_a6 [8] = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b10};

  task automatic check_a6_syms(input string tag);
    check({tag, "_nsym"}, got.size(), 8);
    for (int k = 0; k < 8; k++) check({tag, "_sym"}, (k < got.size()) ? got[k] : 2'bxx, exp_a6[k]);
  endtask

  initial begin
    int lat;
    bit found;
    int ndone;
    sym_if.sym_ready = 1'b0;
    tick();
    tick();
    // Reset values while rst is low
    check("rst_sym_out", sym_if.sym_out, 0);
    check("rst_sym_valid", sym_if.sym_valid, 0);
    check("rst_sym_idx", sym_if.sym_idx, 0);
    check("rst_word", word_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("idle_busy", busy, 0);
    check("idle_valid", sym_if.sym_valid, 0);

`ifndef STATUS_LOOP_EN
    // Straight run of 16'hA6D7
    run_seq(16'hA6D7, -1, 0, 1'b0, 0, lat);
    check("a6_word", word_out, 16'h5182);
    check("a6_latency", lat, 8);
    check_a6_syms("a6");
    check("a6_busy_after", busy, 0);

    // Same sequence with a 3-cycle stall at index 4
    run_seq(16'hA6D7, 4, 3, 1'b0, 0, lat);
    check("stall_latency", lat, 11);
    check_a6_syms("stall");

    // All-idle sequence; second start mid-SEND is ignored
    run_seq(16'h0000, -1, 0, 1'b0, 3, lat);
    check("zero_word", word_out, 16'hFFFF);
    check("zero_latency", lat, 8);
    check("zero_nsym", got.size(), 8);
    for (int k = 0; k < 8; k++) check("zero_sym", (k < got.size()) ? got[k] : 2'bxx, 2'b11);

    // Asynchronous reset at sym_idx 5
    seq_in = 16'hA6D7;
    start = 1'b1;
    sym_if.sym_ready = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (sym_if.sym_idx == 3'd5) found = 1'b1;
      else tick();
    end
    check("reach_idx5", found, 1);
    rst = 1'b0;
    #1;
    check("arst_sym_out", sym_if.sym_out, 0);
    check("arst_valid", sym_if.sym_valid, 0);
    check("arst_idx", sym_if.sym_idx, 0);
    check("arst_word", word_out, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) ndone++;
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) ndone++;
    end
    check("arst_no_done", ndone, 0);
    run_seq(16'hA6D7, -1, 0, 1'b0, 0, lat);
    check("post_rst_latency", lat, 8);
    check_a6_syms("post_rst");

    // Randomised sequences with random back-pressure
    for (int t = 0; t < 20; t++) begin
      run_seq(16'($urandom), -1, 0, 1'b1, int'($urandom_range(0, 12)), lat);
      check("rnd_nsym", got.size(), 8);
      check("rnd_lat_min", lat >= 8, 1);
    end
`else
    // Looping build: three passes in 24 cycles of ready
    seq_in = 16'hA6D7;
    start = 1'b1;
    sym_if.sym_ready = 1'b1;
    tick();
    start = 1'b0;
    got.delete();
    ndone = 0;
    for (int c = 0; c < 24; c++) begin
      tick();
      if (done) ndone++;
    end
    check("loop_word", word_out, 16'h5182);
    check("loop_ndone", ndone, 3);
    check("loop_wrap_idx", sym_if.sym_idx, 0);
    check("loop_busy", busy, 1);
    // Terminate with start held over a last-symbol transfer
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (sym_if.sym_idx == 3'd7) found = 1'b1;
      else tick();
    end
    check("loop_reach_last", found, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("loop_term_done", done, 1);
    tick();
    check("loop_term_busy", busy, 0);
    check("loop_term_valid", sym_if.sym_valid, 0);
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
